// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for the 16-bit accumulator ALU: one command per handshake in,
// sequences the ALU load/execute/capture timing, and returns result/error on a response port.
module alu_cmd_issuer #(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    input  logic             cmd_clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_load,
    output logic             alu_rst,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_FIRST_ILLEGAL = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_EXEC,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           r_state,      w_state;
    logic             r_cmd_ready,  w_cmd_ready;
    logic [WIDTH-1:0] r_alu_a,      w_alu_a;
    logic [WIDTH-1:0] r_alu_b,      w_alu_b;
    logic [3:0]       r_alu_opcode, w_alu_opcode;
    logic             r_alu_load,   w_alu_load;
    logic             r_alu_rst,    w_alu_rst;
    logic             r_rsp_valid,  w_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result, w_rsp_result;
    logic             r_rsp_err,    w_rsp_err;
    logic [CNT_W-1:0] r_err_count,  w_err_count;
    logic [WIDTH-1:0] r_acc,        w_acc;
    logic [3:0]       r_op,         w_op;
    logic [EW-1:0]    r_cnt,        w_cnt;
    logic             r_err,        w_err;
    logic             w_accept;

    // r_cmd_ready is only ever high in IDLE, so it doubles as the accept qualifier.
    assign w_accept = r_cmd_ready & cmd_valid;

    // Every registered output is computed here from the state being entered, so the
    // ALU and response ports see clean flop outputs.
    always_comb begin
        // NOTE: every target gets its hold value first; any path that skips an assignment
        // would otherwise infer a latch.
        w_state      = r_state;
        w_cmd_ready  = r_cmd_ready;
        w_alu_a      = r_alu_a;
        w_alu_b      = r_alu_b;
        w_alu_opcode = r_alu_opcode;
        w_alu_load   = r_alu_load;
        w_alu_rst    = r_alu_rst;
        w_rsp_valid  = r_rsp_valid;
        w_rsp_result = r_rsp_result;
        w_rsp_err    = r_rsp_err;
        w_err_count  = r_err_count;
        w_acc        = r_acc;
        w_op         = r_op;
        w_cnt        = r_cnt;
        w_err        = r_err;

        case (r_state)
            S_IDLE: begin
                w_alu_rst    = 1'b0;
                w_alu_opcode = OP_NOP;
                w_alu_load   = 1'b0;
                w_cmd_ready  = ~w_accept;
                if (w_accept) begin
                    if (cmd_clear) begin
                        w_state   = S_CLEAR;
                        w_alu_rst = 1'b1;
                    end else if (cmd_op >= OP_FIRST_ILLEGAL) begin
                        w_state      = S_RESP;
                        w_rsp_valid  = 1'b1;
                        w_rsp_result = r_acc;
                        w_rsp_err    = 1'b1;
                    end else begin
                        w_state    = S_LOAD;
                        w_op       = cmd_op;
                        w_alu_a    = cmd_chain ? r_acc : cmd_a;
                        w_alu_b    = cmd_b;
                        w_alu_load = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                w_state      = S_RESP;
                w_alu_rst    = 1'b0;
                w_acc        = '0;
                w_rsp_valid  = 1'b1;
                w_rsp_result = '0;
                w_rsp_err    = 1'b0;
            end
            S_LOAD: begin
                w_state      = S_EXEC;
                w_alu_opcode = r_op;
                w_cnt        = EW'(EXEC_CYCLES - 1);
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_state      = S_CAPTURE;
                    w_err        = alu_err;
                    w_alu_opcode = OP_NOP;
                    w_alu_load   = 1'b0;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_CAPTURE: begin
                // The accumulator follows the ALU even on error, so a later chain sees it.
                w_state      = S_RESP;
                w_acc        = alu_result;
                w_rsp_valid  = 1'b1;
                w_rsp_result = alu_result;
                w_rsp_err    = r_err;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    if (r_rsp_err && (r_err_count != {CNT_W{1'b1}})) begin
                        w_err_count = r_err_count + 1'b1;
                    end
                end
            end
            default: begin
                w_state     = S_IDLE;
                w_cmd_ready = 1'b0;
            end
        endcase
    end

    // Reset holds the ALU in its own reset and aborts any in-flight command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= OP_NOP;
            r_alu_load   <= 1'b0;
            r_alu_rst    <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_err_count  <= '0;
            r_acc        <= '0;
            r_op         <= OP_NOP;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            r_state      <= w_state;
            r_cmd_ready  <= w_cmd_ready;
            r_alu_a      <= w_alu_a;
            r_alu_b      <= w_alu_b;
            r_alu_opcode <= w_alu_opcode;
            r_alu_load   <= w_alu_load;
            r_alu_rst    <= w_alu_rst;
            r_rsp_valid  <= w_rsp_valid;
            r_rsp_result <= w_rsp_result;
            r_rsp_err    <= w_rsp_err;
            r_err_count  <= w_err_count;
            r_acc        <= w_acc;
            r_op         <= w_op;
            r_cnt        <= w_cnt;
            r_err        <= w_err;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;
    assign alu_load   = r_alu_load;
    assign alu_rst    = r_alu_rst;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a stand-in accumulator ALU, a transaction-level model of the
// issuer checked every cycle, and directed commands with hand-computed results.
module tb_alu_cmd_issuer;

    localparam int WIDTH       = 16;
    localparam int EXEC_CYCLES = 1;
    localparam int CNT_W       = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = '0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic             cmd_chain = 1'b0;
    logic             cmd_clear = 1'b0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_opcode;
    logic             alu_load;
    logic             alu_rst;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;
    logic [CNT_W-1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.WIDTH(WIDTH), .EXEC_CYCLES(EXEC_CYCLES), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_chain  (cmd_chain),
        .cmd_clear  (cmd_clear),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_load   (alu_load),
        .alu_rst    (alu_rst),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU operation table: returns {err, result}; opcode 0 and unknown codes hold acc.
    function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] acc);
        logic [15:0]        r;
        logic               e;
        logic signed [31:0] p;
        r = acc;
        e = 1'b0;
        p = '0;
        case (op)
            4'd1:  r = a & b;
            4'd2:  r = a | b;
            4'd3:  r = a ^ b;
            4'd4:  r = ~a;
            4'd5:  r = a << 1;
            4'd6:  r = a >> 1;
            4'd7:  r = a;
            4'd8:  if (b == 16'd0) begin r = 16'hFFFF; e = 1'b1; end else r = a / b;
            4'd9:  begin r = a + b; e = (a[15] == b[15]) && (r[15] != a[15]); end
            4'd10: begin r = a - b; e = (a[15] != b[15]) && (r[15] != a[15]); end
            4'd11: begin
                p = $signed(a) * $signed(b);
                r = p[15:0];
                e = (p > 32'sd32767) || (p < -32'sd32768);
            end
            4'd12: r = a + 16'd1;
            4'd13: r = a - 16'd1;
            default: r = acc;
        endcase
        return {e, r};
    endfunction

    // Stand-in ALU: synchronous active-high reset, operand registers, accumulator.
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic [15:0] s_acc = '0;
    logic [16:0] s_fn;

    always_comb s_fn = alu_fn(alu_opcode, s_a, s_b, s_acc);
    assign alu_result = s_acc;
    assign alu_err    = s_fn[16];

    always @(posedge clk) begin
        if (alu_rst) begin
            s_a   <= '0;
            s_b   <= '0;
            s_acc <= '0;
        end else begin
            if (alu_load) begin
                s_a <= alu_a;
                s_b <= alu_b;
            end
            if (alu_opcode != 4'd0) s_acc <= s_fn[15:0];
        end
    end

    // Transaction-level model: one outstanding command, fixed response latency per kind.
    bit          m_started;
    bit          m_ready;
    bit          m_rsp_valid;
    bit          m_exp_err;
    bit          m_clear_pulse;
    logic [15:0] m_acc;
    logic [15:0] m_exp_res;
    logic [15:0] m_a_sel;
    logic [16:0] m_fn;
    int          m_wait;
    int          m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_started = 1'b0;  m_ready = 1'b0;    m_rsp_valid = 1'b0;
            m_exp_err = 1'b0;  m_clear_pulse = 1'b0;
            m_acc = '0;        m_exp_res = '0;    m_wait = 0;  m_cnt = 0;
        end else begin
            m_clear_pulse = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
                m_ready   = 1'b1;
            end else if (m_rsp_valid) begin
                if (rsp_ready) begin
                    if (m_exp_err && m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    m_rsp_valid = 1'b0;
                    m_ready     = 1'b1;
                end
            end else if (m_ready) begin
                if (cmd_valid) begin
                    m_ready = 1'b0;
                    if (cmd_clear) begin
                        m_exp_res = '0;  m_exp_err = 1'b0;  m_acc = '0;
                        m_clear_pulse = 1'b1;
                        m_wait = 1;
                    end else if (cmd_op >= 4'd14) begin
                        m_exp_res = m_acc;  m_exp_err = 1'b1;
                        m_rsp_valid = 1'b1;
                    end else begin
                        m_a_sel   = cmd_chain ? m_acc : cmd_a;
                        m_fn      = alu_fn(cmd_op, m_a_sel, cmd_b, m_acc);
                        m_acc     = m_fn[15:0];
                        m_exp_res = m_fn[15:0];
                        m_exp_err = m_fn[16];
                        m_wait    = 2 + EXEC_CYCLES;
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_rsp_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            if (m_rsp_valid) begin
                check("rsp_result", 32'(rsp_result), 32'(m_exp_res));
                check("rsp_err", 32'(rsp_err), 32'(m_exp_err));
            end
            check("err_count", 32'(err_count), 32'(m_cnt));
            check("alu_rst", 32'(alu_rst), 32'(!m_started || m_clear_pulse));
            if (m_ready || m_rsp_valid) check("alu_opcode_idle", 32'(alu_opcode), 32'd0);
        end
    end

    // Issue one command from a negedge, return the response and the number of negedges
    // between the one just after the handshake edge and the first with rsp_valid high.
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic chain, input logic clear, input int hold,
                          output logic [15:0] res, output logic err, output int lat);
        int k;
        cmd_op = op;  cmd_a = a;  cmd_b = b;  cmd_chain = chain;  cmd_clear = clear;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a = ~a;  cmd_b = ~b;  cmd_op = 4'd1;  cmd_chain = ~chain;  cmd_clear = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_arrival", 32'(rsp_valid), 32'd1);
        res = rsp_result;
        err = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [15:0] r_res;
    logic        r_err;
    int          r_lat;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_load", 32'(alu_load), 32'd0);
        check("rst_alu_rst", 32'(alu_rst), 32'd1);

        // Release with cmd_valid already up: the first edge cannot accept it.
        cmd_valid = 1'b1;  cmd_op = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("release_cmd_ready", 32'(cmd_ready), 32'd1);
        check("release_alu_rst", 32'(alu_rst), 32'd0);
        check("release_no_rsp", 32'(rsp_valid), 32'd0);

        do_cmd(4'd9, 16'd3, 16'd4, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        check("add_3_4", 32'(r_res), 32'd7);
        check("add_3_4_err", 32'(r_err), 32'd0);
        check("add_latency", 32'(r_lat), 32'd3);

        do_cmd(4'd9, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        check("add_ovf", 32'(r_res), 32'hFFFE);
        check("add_ovf_err", 32'(r_err), 32'd1);
        check("add_ovf_count", 32'(err_count), 32'd1);

        do_cmd(4'd8, 16'd10, 16'd0, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        check("div0_err", 32'(r_err), 32'd1);
        check("div0_count", 32'(err_count), 32'd2);

        do_cmd(4'd9, 16'd5, 16'd3, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        check("add_5_3", 32'(r_res), 32'd8);
        do_cmd(4'd11, 16'h1234, 16'd2, 1'b1, 1'b0, 0, r_res, r_err, r_lat);
        check("chain_mult", 32'(r_res), 32'd16);
        check("chain_mult_err", 32'(r_err), 32'd0);
        do_cmd(4'd10, 16'h4321, 16'd6, 1'b1, 1'b0, 0, r_res, r_err, r_lat);
        check("chain_sub", 32'(r_res), 32'd10);
        check("chain_sub_err", 32'(r_err), 32'd0);

        do_cmd(4'd0, 16'h0055, 16'h00AA, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        check("nop_returns_acc", 32'(r_res), 32'd10);
        check("nop_err", 32'(r_err), 32'd0);

        do_cmd(4'hE, 16'd1, 16'd1, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        check("illegal_result", 32'(r_res), 32'd10);
        check("illegal_err", 32'(r_err), 32'd1);
        check("illegal_latency", 32'(r_lat), 32'd0);

        do_cmd(4'd9, 16'd9, 16'd9, 1'b0, 1'b1, 0, r_res, r_err, r_lat);
        check("clear_result", 32'(r_res), 32'd0);
        check("clear_latency", 32'(r_lat), 32'd1);
        do_cmd(4'd0, 16'd7, 16'd7, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        check("nop_after_clear", 32'(r_res), 32'd0);

        do_cmd(4'd9, 16'd1, 16'd2, 1'b0, 1'b0, 5, r_res, r_err, r_lat);
        check("held_rsp", 32'(r_res), 32'd3);

        // Abort in the middle of EXEC: everything returns to reset values, no response.
        cmd_op = 4'd9;  cmd_a = 16'd100;  cmd_b = 16'd1;  cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_result", 32'(rsp_result), 32'd0);
        check("abort_err_count", 32'(err_count), 32'd0);
        check("abort_alu_opcode", 32'(alu_opcode), 32'd0);
        check("abort_alu_load", 32'(alu_load), 32'd0);
        check("abort_alu_rst", 32'(alu_rst), 32'd1);
        check("abort_alu_ab", 32'({alu_a, alu_b}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 260; i++) begin
            do_cmd(4'hF, 16'd0, 16'd0, 1'b0, 1'b0, 0, r_res, r_err, r_lat);
        end
        check("err_count_saturated", 32'(err_count), 32'd255);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
